rgb_freq_sampler: RTL and testbench
===================================

// Module: rgb_freq_sampler
// PURPOSE
//  Upstream front end for the colour comparator. Drives the TCS3200-style colour
//  sensor's filter-select pins (s2/s3) and measures the sensor's pulse output frequency.
//  Per filter (red, green, blue) it counts rising edges over a fixed gate window.
//  The count is scaled and saturated to 8 bits. It publishes a coherent {R,G,B}
//  triple plus a one-cycle valid strobe; these feed the R7..R0/G7..G0/B7..B0 system inputs.
// PARAMETERS
//  GATE_CYCLES    1000  clk cycles per count window (>=4)
//  SETTLE_CYCLES  16    clk cycles after a filter change before counting (>=1)
//  SHIFT          0     right shift applied to raw count before 8-bit saturation (0..8)
//  CNT_W          16    raw edge-counter width; must hold GATE_CYCLES/2
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  asynchronous, active-low reset
//  en          in   1  1 = run continuous frames; 0 = stop/abort
//  sensor_out  in   1  asynchronous square wave from sensor
//  s2          out  1  filter select bit S2
//  s3          out  1  filter select bit S3
//  red_v       out  8  last red measurement
//  green_v     out  8  last green measurement
//  blue_v      out  8  last blue measurement
//  valid       out  1  1-cycle strobe: new triple on red_v/green_v/blue_v
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; red_v=green_v=blue_v=0; valid=0; s2=1, s3=0 (clear filter).
//   Reset also clears the raw counter and synchronizer flops. Deassertion takes effect on the next clk edge.
//  Filter encoding (s2,s3): RED=00, BLUE=01, CLEAR=10, GREEN=11. s2/s3 are registered,
//   updated on entry to each SETTLE state.
//  sensor_out passes through a 2-flop synchronizer, then a registered rising-edge detector.
//   Edge pulse latency is 3 clk. Edges detected only while in a COUNT state are counted.
//  Raw counter: cleared on entry to every SETTLE state. It increments by 1 per edge pulse.
//   It holds at all-ones, never wraps.
//  Result = (raw >> SHIFT). If the result is > 255 the output is 255, else result[7:0].
//  FSM: IDLE -> SET_R -> CNT_R -> SET_G -> CNT_G -> SET_B -> CNT_B -> UPD.
//   IDLE: s2/s3=CLEAR. When en=1 at an edge, go to SET_R.
//   SET_x: stays exactly SETTLE_CYCLES cycles with filter x selected.
//   CNT_x: stays exactly GATE_CYCLES cycles. The scaled/saturated count is latched into a
//    per-colour holding register on exit.
//   UPD: 1 cycle. red_v/green_v/blue_v load from the holding regs on the same edge that
//    sets valid=1. valid drops on the following edge.
//    Next state is SET_R if en=1, else IDLE.
//  Frame period = 3*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles. First valid comes that many
//   cycles after the first SET_R cycle.
//  The three outputs change only together at UPD. A partial frame never reaches the outputs.
//  en=0 in any SET/CNT/UPD-pending state aborts the frame: next state is IDLE.
//   Outputs keep their previous values, valid stays 0, and holding regs are discarded.
//  en re-asserted after an abort always restarts at SET_R (red).
//  Reset mid-frame: immediate return to reset values. No valid is produced for the interrupted frame.
//  Counter saturation and output saturation are independent. Both must clip, never wrap.
// TESTING
//  (bench model: sensor_out period depends on s2/s3; GATE=100, SETTLE=4, SHIFT=0
//   unless noted; counts are checked to +/-1 for phase)
//  1 Periods red=10, green=20, blue=4 clk; en=1 -> valid after 313 cycles,
//    red_v=10, green_v=5, blue_v=25; check s2/s3 = 00, 11, 01 during the three windows.
//  2 Same stimulus, en held 1 -> valid pulses exactly 313 cycles apart, each 1 cycle wide.
//    Values are stable between pulses.
//  3 Saturation: GATE=1000, all periods=2 -> 500 edges -> all outputs 255.
//    With SHIFT=1: 250.
//  4 sensor_out held 0 -> a frame completes with 0,0,0 and valid=1.
//  5 Abort: after frame 1 (10,5,25), drop en during CNT_G -> IDLE, s2/s3=10, no valid, outputs unchanged.
//    Re-enable -> next valid 313 cycles later with fresh values.
//  6 rst=0 pulse mid CNT_B (asynchronous, between clk edges) -> outputs 0, valid 0,
//    s2/s3=10 immediately; after release with en=1, a full new frame is required.

Source files
------------

// File: rtl/rgb_freq_sampler.sv
// rgb_freq_sampler
//   Front end for the colour comparator. Steps a TCS3200-style sensor through its
//   red, green and blue filters (s2/s3), counts rising edges of the sensor's pulse
//   output over a fixed gate window per filter, scales and saturates each count to
//   8 bits, and publishes a coherent {R,G,B} triple with a one-cycle valid strobe.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-low reset
//   en          in   1 = run continuous frames, 0 = stop/abort the current frame
//   sensor_out  in   asynchronous square wave from the sensor
//   s2, s3      out  filter select (RED=00, BLUE=01, CLEAR=10, GREEN=11)
//   red_v       out  last complete red measurement
//   green_v     out  last complete green measurement
//   blue_v      out  last complete blue measurement
//   valid       out  one-cycle strobe, new triple on red_v/green_v/blue_v
module rgb_freq_sampler #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int SHIFT         = 0,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sensor_out,
  output logic       s2,
  output logic       s3,
  output logic [7:0] red_v,
  output logic [7:0] green_v,
  output logic [7:0] blue_v,
  output logic       valid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET_R = 3'd1,
    CNT_R = 3'd2,
    SET_G = 3'd3,
    CNT_G = 3'd4,
    SET_B = 3'd5,
    CNT_B = 3'd6,
    UPD   = 3'd7
  } state_t;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Counter holds at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) return c;
    return c + 1'b1;
  endfunction

  // Scale by SHIFT, then clip to 8 bits.
  function automatic logic [7:0] sat8(input logic [CNT_W-1:0] raw);
    logic [CNT_W-1:0] sh;
    sh = raw >> SHIFT;
    if (sh > CNT_W'(255)) return 8'hFF;
    return sh[7:0];
  endfunction

  state_t           state, state_nx;
  logic [TMR_W-1:0] tmr;
  logic             last;

  logic             sync_p0, sync_p1, sync_p2, edge_p3;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       hold_r, hold_g, hold_b;

  logic             filt_load;
  logic [1:0]       filt_val;
  logic             cnt_clr, cnt_run;
  logic             latch_r, latch_g, latch_b, publish;

  // Stage p0/p1: two-flop synchronizer for the asynchronous sensor input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sensor_out;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2/p3: registered rising-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p2 <= 1'b0;
      edge_p3 <= 1'b0;
    end else begin
      sync_p2 <= sync_p1;
      edge_p3 <= sync_p1 & ~sync_p2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Dwell timer: restarts on every state change, parked at zero in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  tmr <= '0;
    else if (state_nx != state || state == IDLE) tmr <= '0;
    else                                       tmr <= tmr + 1'b1;
  end

  always_comb begin
    last = 1'b0;
    case (state)
      SET_R, SET_G, SET_B: last = (tmr == TMR_W'(SETTLE_CYCLES - 1));
      CNT_R, CNT_G, CNT_B: last = (tmr == TMR_W'(GATE_CYCLES - 1));
      UPD:                 last = 1'b1;
      default:             last = 1'b0;
    endcase
  end

  // FSM next state: en low anywhere in the frame abandons it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = en ? SET_R : IDLE;
      SET_R:   state_nx = !en ? IDLE : (last ? CNT_R : SET_R);
      CNT_R:   state_nx = !en ? IDLE : (last ? SET_G : CNT_R);
      SET_G:   state_nx = !en ? IDLE : (last ? CNT_G : SET_G);
      CNT_G:   state_nx = !en ? IDLE : (last ? SET_B : CNT_G);
      SET_B:   state_nx = !en ? IDLE : (last ? CNT_B : SET_B);
      CNT_B:   state_nx = !en ? IDLE : (last ? UPD : CNT_B);
      UPD:     state_nx = en ? SET_R : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs (decoded controls for the registered datapath)
  always_comb begin
    filt_load = (state_nx != state);
    filt_val  = FILT_CLEAR;
    case (state_nx)
      SET_R:   filt_val = FILT_RED;
      SET_G:   filt_val = FILT_GREEN;
      SET_B:   filt_val = FILT_BLUE;
      IDLE:    filt_val = FILT_CLEAR;
      default: filt_load = 1'b0;
    endcase
    cnt_clr = (state == SET_R) || (state == SET_G) || (state == SET_B);
    cnt_run = (state == CNT_R) || (state == CNT_G) || (state == CNT_B);
    latch_r = (state == CNT_R) && last;
    latch_g = (state == CNT_G) && last;
    latch_b = (state == CNT_B) && last;
    publish = (state == UPD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           {s2, s3} <= FILT_CLEAR;
    else if (filt_load) {s2, s3} <= filt_val;
  end

  // Stage p4: gated edge counter
  always_comb begin
    cnt_nx = cnt;
    if (cnt_run && edge_p3) cnt_nx = sat_inc(cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt_nx;
  end

  // Stage p5: per-colour holding registers, loaded with the final count of each
  // window (cnt_nx so an edge in the last gate cycle is not lost).
  always_ff @(posedge clk) begin
    if (latch_r) hold_r <= sat8(cnt_nx);
    if (latch_g) hold_g <= sat8(cnt_nx);
    if (latch_b) hold_b <= sat8(cnt_nx);
  end

  // Stage p6: published triple, updated only from a completed frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red_v   <= 8'd0;
      green_v <= 8'd0;
      blue_v  <= 8'd0;
      valid   <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        red_v   <= hold_r;
        green_v <= hold_g;
        blue_v  <= hold_b;
      end
    end
  end

endmodule

// File: tb/tb_rgb_freq_sampler.sv
module tb_rgb_freq_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sensor_out;
  logic       s2, s3;
  logic [7:0] red_v, green_v, blue_v;
  logic       valid;

  logic       en_sat;
  logic       sens_sat;
  logic       s2_a, s3_a, valid_a;
  logic [7:0] r_a, g_a, b_a;
  logic       s2_b, s3_b, valid_b;
  logic [7:0] r_b, g_b, b_b;

  logic       zero_mode;
  logic       alt_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_freq_sampler #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .SHIFT(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .sensor_out(sensor_out),
    .s2(s2), .s3(s3), .red_v(red_v), .green_v(green_v), .blue_v(blue_v), .valid(valid)
  );

  rgb_freq_sampler #(.GATE_CYCLES(1000), .SETTLE_CYCLES(4), .SHIFT(0), .CNT_W(16)) dut_sat0 (
    .clk(clk), .rst(rst), .en(en_sat), .sensor_out(sens_sat),
    .s2(s2_a), .s3(s3_a), .red_v(r_a), .green_v(g_a), .blue_v(b_a), .valid(valid_a)
  );

  rgb_freq_sampler #(.GATE_CYCLES(1000), .SETTLE_CYCLES(4), .SHIFT(1), .CNT_W(16)) dut_sat1 (
    .clk(clk), .rst(rst), .en(en_sat), .sensor_out(sens_sat),
    .s2(s2_b), .s3(s3_b), .red_v(r_b), .green_v(g_b), .blue_v(b_b), .valid(valid_b)
  );

  // Sensor model: period (in clk) depends on the selected filter.
  function automatic int period_of(input logic [1:0] f, input logic alt);
    case (f)
      2'b00:   return alt ? 5 : 10;
      2'b11:   return alt ? 10 : 20;
      2'b01:   return alt ? 20 : 4;
      default: return 8;
    endcase
  endfunction

  initial begin
    int ph;
    int per;
    ph = 0;
    sensor_out = 1'b0;
    forever begin
      @(negedge clk);
      if (zero_mode) begin
        sensor_out = 1'b0;
      end else begin
        per = period_of({s2, s3}, alt_mode);
        ph = (ph + 1) % per;
        sensor_out = (ph < per / 2);
      end
    end
  end

  initial begin
    sens_sat = 1'b0;
    forever begin
      @(negedge clk);
      sens_sat = ~sens_sat;
    end
  end

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (red_v !== 8'd0 || green_v !== 8'd0 || blue_v !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: got %0d,%0d,%0d want 0,0,0", red_v, green_v, blue_v); end
    checks++; if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if ({s2, s3} !== 2'b10) begin
      errors++; $display("FAIL reset_filter: got %b want 10", {s2, s3}); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if ({s2, s3} !== 2'b10 || valid !== 1'b0) begin
      errors++; $display("FAIL idle_hold: filter %b valid %b want 10 0", {s2, s3}, valid); end
  endtask

  task automatic test_frame();
    int n;
    n = -1;
    @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (i == 50) begin
        checks++; if ({s2, s3} !== 2'b00) begin
          errors++; $display("FAIL filter_red: got %b want 00", {s2, s3}); end
      end
      if (i == 150) begin
        checks++; if ({s2, s3} !== 2'b11) begin
          errors++; $display("FAIL filter_green: got %b want 11", {s2, s3}); end
      end
      if (i == 250) begin
        checks++; if ({s2, s3} !== 2'b01) begin
          errors++; $display("FAIL filter_blue: got %b want 01", {s2, s3}); end
      end
      if (valid) begin
        n = i;
        break;
      end
    end
    checks++; if (n != 314) begin
      errors++; $display("FAIL first_valid_latency: got %0d edges want 314", n); end
    checks++; if (int'(red_v) < 9 || int'(red_v) > 11) begin
      errors++; $display("FAIL frame_red: got %0d want 10+/-1", red_v); end
    checks++; if (int'(green_v) < 4 || int'(green_v) > 6) begin
      errors++; $display("FAIL frame_green: got %0d want 5+/-1", green_v); end
    checks++; if (int'(blue_v) < 24 || int'(blue_v) > 26) begin
      errors++; $display("FAIL frame_blue: got %0d want 25+/-1", blue_v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, g0, b0;
    int n;
    r0 = red_v; g0 = green_v; b0 = blue_v;
    n = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checks++; if (valid !== 1'b0) begin
          errors++; $display("FAIL valid_width: got %b want 0 one cycle after strobe", valid); end
      end
      if (k == 200) begin
        checks++; if (red_v !== r0 || green_v !== g0 || blue_v !== b0) begin
          errors++; $display("FAIL stable_between: got %0d,%0d,%0d want %0d,%0d,%0d",
                              red_v, green_v, blue_v, r0, g0, b0); end
      end
      if (valid) begin
        n = k;
        break;
      end
    end
    checks++; if (n != 313) begin
      errors++; $display("FAIL frame_period: got %0d want 313", n); end
    checks++; if (int'(red_v) < 9 || int'(red_v) > 11 || int'(green_v) < 4 || int'(green_v) > 6 ||
                  int'(blue_v) < 24 || int'(blue_v) > 26) begin
      errors++; $display("FAIL frame2_values: got %0d,%0d,%0d want 10,5,25 +/-1", red_v, green_v, blue_v); end
  endtask

  task automatic test_abort();
    logic [7:0] r0, g0, b0;
    int pulses;
    int n;
    r0 = red_v; g0 = green_v; b0 = blue_v;
    repeat (149) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    checks++; if ({s2, s3} !== 2'b10) begin
      errors++; $display("FAIL abort_filter: got %b want 10", {s2, s3}); end
    pulses = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    checks++; if (pulses != 0) begin
      errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", pulses); end
    checks++; if (red_v !== r0 || green_v !== g0 || blue_v !== b0) begin
      errors++; $display("FAIL abort_outputs_kept: got %0d,%0d,%0d want %0d,%0d,%0d",
                          red_v, green_v, blue_v, r0, g0, b0); end
    alt_mode = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_valid(400, n);
    checks++; if (n != 314) begin
      errors++; $display("FAIL restart_latency: got %0d want 314", n); end
    checks++; if (int'(red_v) < 19 || int'(red_v) > 21 || int'(green_v) < 9 || int'(green_v) > 11 ||
                  int'(blue_v) < 4 || int'(blue_v) > 6) begin
      errors++; $display("FAIL restart_values: got %0d,%0d,%0d want 20,10,5 +/-1", red_v, green_v, blue_v); end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (260) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (red_v !== 8'd0 || green_v !== 8'd0 || blue_v !== 8'd0 || valid !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %0d,%0d,%0d valid %b want 0,0,0 0",
                          red_v, green_v, blue_v, valid); end
    checks++; if ({s2, s3} !== 2'b10) begin
      errors++; $display("FAIL midreset_filter: got %b want 10", {s2, s3}); end
    @(negedge clk);
    rst = 1'b1;
    wait_valid(400, n);
    checks++; if (n != 314) begin
      errors++; $display("FAIL midreset_full_frame: got %0d want 314", n); end
    checks++; if (int'(red_v) < 19 || int'(red_v) > 21 || int'(blue_v) < 4 || int'(blue_v) > 6) begin
      errors++; $display("FAIL midreset_values: got %0d,%0d,%0d want 20,10,5 +/-1", red_v, green_v, blue_v); end
  endtask

  task automatic test_zero();
    int n;
    @(negedge clk);
    en = 1'b0;
    zero_mode = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_valid(400, n);
    checks++; if (n != 314) begin
      errors++; $display("FAIL zero_valid: got %0d want 314", n); end
    checks++; if (red_v !== 8'd0 || green_v !== 8'd0 || blue_v !== 8'd0) begin
      errors++; $display("FAIL zero_values: got %0d,%0d,%0d want 0,0,0", red_v, green_v, blue_v); end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_saturation();
    int n;
    n = -1;
    @(negedge clk);
    en_sat = 1'b1;
    for (int i = 1; i <= 3200; i++) begin
      @(posedge clk); #1;
      if (valid_a) begin
        n = i;
        break;
      end
    end
    checks++; if (n != 3014) begin
      errors++; $display("FAIL sat_latency: got %0d want 3014", n); end
    checks++; if (valid_b !== 1'b1) begin
      errors++; $display("FAIL sat_shift_valid: got %b want 1", valid_b); end
    checks++; if (r_a !== 8'd255 || g_a !== 8'd255 || b_a !== 8'd255) begin
      errors++; $display("FAIL sat_clip: got %0d,%0d,%0d want 255,255,255", r_a, g_a, b_a); end
    checks++; if (int'(r_b) < 249 || int'(r_b) > 251 || int'(g_b) < 249 || int'(g_b) > 251 ||
                  int'(b_b) < 249 || int'(b_b) > 251) begin
      errors++; $display("FAIL sat_shift1: got %0d,%0d,%0d want 250 +/-1", r_b, g_b, b_b); end
    @(negedge clk);
    en_sat = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    en_sat = 1'b0;
    zero_mode = 1'b0;
    alt_mode = 1'b0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_zero();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
